pipeline_hazard_controller: RTL and testbench

Central sequencer for the 16-bit, 16-register five-stage pipeline. It drives the enable, flush and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three hazard classes:
- load-use hazards;
- taken-branch redirects;
- multi-cycle data-memory accesses signalled by a req/ack handshake.

It includes a watchdog that latches a fatal error when memory never acknowledges, and an optional stall-cycle counter.

---
 rtl/pipeline_hazard_controller.sv | 152 +++++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// pipeline_hazard_controller
// Central hazard sequencer for the five-stage pipeline: drives the PC and
// pipeline-register enable/flush/bubble controls. It resolves load-use
// hazards, taken-branch redirects and multi-cycle data-memory accesses
// (req/ack). A watchdog latches a sticky error if memory never acknowledges.
// Optional feature macro: HAZARD_STALL_COUNTER_EN builds a saturating
// 16-bit count of cycles with pc_en low; without it stall_count is tied to 0.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W  = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_is_load,
  input  logic                  branch_taken_ex,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  pc_en,
  output logic                  en_fetch_decode,
  output logic                  en_decode_execute,
  output logic                  en_execute_memory,
  output logic                  flush_fetch_decode,
  output logic                  flush_decode_execute,
  output logic                  bubble_memory_writeback,
  output logic                  mem_busy,
  output logic                  mem_timeout_err,
  output logic [15:0]           stall_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;

  // Last wait-counter value before giving up on the memory.
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_wait;
  logic       load_use;

  // The memory stage is holding the pipe this cycle (an ack releases it at once).
  assign mem_wait = ((state_q == ST_RUN) && mem_req && !mem_ack) ||
                    ((state_q == ST_MEM_WAIT) && !mem_ack);

  // Register 0 is hardwired zero, so a load targeting it never creates a hazard.
  assign load_use = ex_is_load && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  assign mem_busy        = (state_q == ST_MEM_WAIT);
  assign mem_timeout_err = (state_q == ST_ERROR);

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Next-state logic: enter MEM_WAIT on an un-acked request, time out to ERROR.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ack) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = 8'd0;
        end
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  // Prioritised control decode; everything is held quiet while reset is high.
  always_comb begin
    pc_en                   = 1'b0;
    en_fetch_decode         = 1'b0;
    en_decode_execute       = 1'b0;
    en_execute_memory       = 1'b0;
    flush_fetch_decode      = 1'b0;
    flush_decode_execute    = 1'b0;
    bubble_memory_writeback = 1'b0;
    if (!reset) begin
      if (state_q == ST_ERROR) begin
        bubble_memory_writeback = 1'b1;
      end else if (mem_wait) begin
        bubble_memory_writeback = 1'b1;
      end else if (branch_taken_ex) begin
        // Younger instructions are on the wrong path; a load-use hit there is moot.
        pc_en                = 1'b1;
        en_fetch_decode      = 1'b1;
        en_decode_execute    = 1'b1;
        en_execute_memory    = 1'b1;
        flush_fetch_decode   = 1'b1;
        flush_decode_execute = 1'b1;
      end else if (load_use) begin
        // Hold PC and IF/ID one cycle, inject a NOP into ID/EX.
        en_decode_execute    = 1'b1;
        en_execute_memory    = 1'b1;
        flush_decode_execute = 1'b1;
      end else begin
        pc_en             = 1'b1;
        en_fetch_decode   = 1'b1;
        en_decode_execute = 1'b1;
        en_execute_memory = 1'b1;
      end
    end
  end

`ifdef HAZARD_STALL_COUNTER_EN
  logic [15:0] stall_cnt_q;

  // Count every cycle the PC is held, saturating at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= 16'h0000;
    end else if (!pc_en && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'h0001;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller. Expected outputs come
// from a cycle-level model of the hazard rules (wait-cycle count, sticky
// error flag, stall total) driven alongside randomized stimulus.
module tb_pipeline_hazard_controller;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  id_rs1, id_rs2, ex_rd;
  logic        ex_is_load, branch_taken_ex, mem_req, mem_ack;
  logic        pc_en, en_fetch_decode, en_decode_execute, en_execute_memory;
  logic        flush_fetch_decode, flush_decode_execute, bubble_memory_writeback;
  logic        mem_busy, mem_timeout_err;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: cycles already spent waiting (-1 = not waiting), error, stalls.
  int m_wait;
  bit m_err;
  int m_stalls;

  // Captured vectors: {pc,fd,de,em,flush_fd,flush_de,bubble,busy,err}.
  logic [8:0]  exp_ctl, act_ctl;
  logic [15:0] exp_cnt, act_cnt;

  pipeline_hazard_controller #(.REG_ADDR_W(4), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd),
    .ex_is_load(ex_is_load), .branch_taken_ex(branch_taken_ex),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .en_fetch_decode(en_fetch_decode),
    .en_decode_execute(en_decode_execute), .en_execute_memory(en_execute_memory),
    .flush_fetch_decode(flush_fetch_decode), .flush_decode_execute(flush_decode_execute),
    .bubble_memory_writeback(bubble_memory_writeback),
    .mem_busy(mem_busy), .mem_timeout_err(mem_timeout_err),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] capture();
    return {pc_en, en_fetch_decode, en_decode_execute, en_execute_memory,
            flush_fetch_decode, flush_decode_execute, bubble_memory_writeback,
            mem_busy, mem_timeout_err};
  endfunction

  task automatic model_reset();
    m_wait = -1; m_err = 1'b0; m_stalls = 0;
  endtask

  // One pipeline cycle: drive, sample at negedge, advance model at posedge.
  task automatic step(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                      input logic ld, input logic br, input logic req, input logic ack);
    bit waiting, stall_mem, lu;
    id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
    ex_is_load = ld; branch_taken_ex = br; mem_req = req; mem_ack = ack;
    @(negedge clk);
    waiting   = (m_wait >= 0);
    stall_mem = waiting ? !ack : (req && !ack);
    lu        = ld && (rd != 4'd0) && (rd == rs1 || rd == rs2);
    if (m_err)          exp_ctl = 9'b0000_001_0_1;
    else if (stall_mem) exp_ctl = {7'b0000_001, waiting, 1'b0};
    else if (br)        exp_ctl = {7'b1111_110, waiting, 1'b0};
    else if (lu)        exp_ctl = {7'b0011_010, waiting, 1'b0};
    else                exp_ctl = {7'b1111_000, waiting, 1'b0};
`ifdef HAZARD_STALL_COUNTER_EN
    exp_cnt = 16'(m_stalls);
`else
    exp_cnt = 16'h0000;
`endif
    act_ctl = capture();
    act_cnt = stall_count;
    @(posedge clk);
    if (!exp_ctl[8] && m_stalls < 65535) m_stalls++;
    if (!m_err) begin
      if (waiting) begin
        if (ack) m_wait = -1;
        else if (m_wait + 1 == TO) begin m_err = 1'b1; m_wait = -1; end
        else m_wait++;
      end else if (req && !ack) begin
        m_wait = 0;
      end
    end
    #1;
  endtask

  task automatic assert_reset();
    reset = 1'b1;
    #3;
    act_ctl = capture();
    act_cnt = stall_count;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    assert_reset();
    n_checks++;
    if (act_ctl !== 9'd0) begin
      n_fail++; $display("FAIL reset_ctl got=%b want=%b", act_ctl, 9'd0);
    end
    n_checks++;
    if (act_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_cnt got=%0d want=0", act_cnt);
    end
    release_reset();
    step(4'd1, 4'd2, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    $display("reset idle ctl=%b cnt=%0d", act_ctl, act_cnt);
    n_checks++;
    if (act_ctl !== 9'b1111_000_0_0) begin
      n_fail++; $display("FAIL idle_ctl got=%b want=%b", act_ctl, 9'b1111_000_0_0);
    end
    n_checks++;
    if (act_cnt !== 16'd0) begin
      n_fail++; $display("FAIL idle_cnt got=%0d want=0", act_cnt);
    end
  endtask

  task automatic test_load_use();
    step(4'd5, 4'd3, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("load_use rd=3 rs2=3 ctl=%b", act_ctl);
    n_checks++;
    if (act_ctl !== 9'b0011_010_0_0) begin
      n_fail++; $display("FAIL load_use_hit got=%b want=%b", act_ctl, 9'b0011_010_0_0);
    end
    step(4'd0, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("load_use rd=0 ctl=%b", act_ctl);
    n_checks++;
    if (act_ctl !== 9'b1111_000_0_0) begin
      n_fail++; $display("FAIL load_use_r0 got=%b want=%b", act_ctl, 9'b1111_000_0_0);
    end
    for (int i = 0; i < 40; i++) begin
      step(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom_range(0, 3) == 0), 1'b0, 1'b0);
      $display("load_use rnd %0d ctl=%b cnt=%0d", i, act_ctl, act_cnt);
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL load_use_rnd %0d got=%b want=%b", i, act_ctl, exp_ctl);
      end
      n_checks++;
      if (act_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL load_use_cnt %0d got=%0d want=%0d", i, act_cnt, exp_cnt);
      end
    end
  endtask

  // Request with ack on cycle k (k = 0 means single-cycle access).
  task automatic test_mem_wait(input int k, input logic br);
    int busy_cycles = 0;
    int bubble_cycles = 0;
    for (int i = 0; i <= k; i++) begin
      step(4'd1, 4'd2, 4'd7, 1'b0, br, 1'b1, 1'(i == k));
      $display("mem_wait k=%0d br=%0d cyc=%0d ctl=%b cnt=%0d", k, br, i, act_ctl, act_cnt);
      busy_cycles   += int'(act_ctl[1]);
      bubble_cycles += int'(act_ctl[2]);
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL mem_wait_ctl k=%0d cyc=%0d got=%b want=%b", k, i, act_ctl, exp_ctl);
      end
      n_checks++;
      if (act_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL mem_wait_cnt k=%0d cyc=%0d got=%0d want=%0d", k, i, act_cnt, exp_cnt);
      end
    end
    n_checks++;
    if (busy_cycles != k || bubble_cycles != k) begin
      n_fail++; $display("FAIL mem_wait_len k=%0d busy=%0d bubble=%0d want=%0d", k, busy_cycles, bubble_cycles, k);
    end
  endtask

  task automatic test_timeout();
    int busy_cycles = 0;
    for (int i = 0; i < TO + 5; i++) begin
      step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      $display("timeout cyc=%0d ctl=%b cnt=%0d", i, act_ctl, act_cnt);
      busy_cycles += int'(act_ctl[1]);
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL timeout_ctl cyc=%0d got=%b want=%b", i, act_ctl, exp_ctl);
      end
      n_checks++;
      if (act_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL timeout_cnt cyc=%0d got=%0d want=%0d", i, act_cnt, exp_cnt);
      end
    end
    n_checks++;
    if (busy_cycles != TO || act_ctl[0] !== 1'b1) begin
      n_fail++; $display("FAIL timeout_len busy=%0d want=%0d err=%b", busy_cycles, TO, act_ctl[0]);
    end
    assert_reset();
    $display("timeout reset ctl=%b cnt=%0d", act_ctl, act_cnt);
    n_checks++;
    if (act_ctl !== 9'd0 || act_cnt !== 16'd0) begin
      n_fail++; $display("FAIL timeout_reset got=%b/%0d want=0/0", act_ctl, act_cnt);
    end
    release_reset();
  endtask

  task automatic test_reset_mid_wait();
    for (int i = 0; i < 3; i++) step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    assert_reset();
    $display("mid_wait reset ctl=%b cnt=%0d", act_ctl, act_cnt);
    n_checks++;
    if (act_ctl !== 9'd0 || act_cnt !== 16'd0) begin
      n_fail++; $display("FAIL mid_wait_reset got=%b/%0d want=0/0", act_ctl, act_cnt);
    end
    release_reset();
    step(4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (act_ctl !== 9'b1111_000_0_0) begin
      n_fail++; $display("FAIL mid_wait_after got=%b want=%b", act_ctl, 9'b1111_000_0_0);
    end
  endtask

  task automatic test_random();
    logic req, ack;
    for (int i = 0; i < 300; i++) begin
      if (m_wait >= 0) begin
        req = 1'b1; ack = 1'($urandom_range(0, 2) == 0);
      end else begin
        req = 1'($urandom_range(0, 2) == 0); ack = req & 1'($urandom);
      end
      step(4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom), 1'($urandom_range(0, 3) == 0), req, ack);
      $display("random cyc=%0d req=%0d ack=%0d ctl=%b cnt=%0d", i, req, ack, act_ctl, act_cnt);
      n_checks++;
      if (act_ctl !== exp_ctl) begin
        n_fail++; $display("FAIL random_ctl cyc=%0d got=%b want=%b", i, act_ctl, exp_ctl);
      end
      n_checks++;
      if (act_cnt !== exp_cnt) begin
        n_fail++; $display("FAIL random_cnt cyc=%0d got=%0d want=%0d", i, act_cnt, exp_cnt);
      end
      if (m_err) begin
        assert_reset();
        release_reset();
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    ex_is_load = 1'b0; branch_taken_ex = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_load_use();
    test_mem_wait(3, 1'b0);
    test_mem_wait(2, 1'b1);
    test_mem_wait(0, 1'b0);
    for (int i = 0; i < 6; i++) test_mem_wait(int'($urandom_range(1, TO - 1)), 1'($urandom));
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
